jtag_vector_sequencer: RTL and testbench

Feeds (TMS,TDI) vector pairs to the JTAG pin driver, one per TCK period, from a 32-bit host word stream. It collects the returned TDO bits into 16-bit words. It sits between the host-side command FIFO and the pin driver, answering the driver's per-period `get_next_data` request. It is the only block that sequences pin-level JTAG traffic.

---
 rtl/jtag_seq_pkg.sv | 37 +++
 rtl/jtag_vector_sequencer_packer.sv | 59 +++++
 rtl/jtag_vector_sequencer.sv | 156 +++++++++++++++
 tb/tb_jtag_vector_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_seq_pkg.sv
// Shared definitions for the JTAG vector sequencer: header field layout,
// FSM states and word/pair sizing helpers.
package jtag_seq_pkg;

   localparam int N_LSB          = 0;
   localparam int N_MSB          = 15;
   localparam int CAP_BIT        = 16;
   localparam int IDLE_TMS_BIT   = 17;
   localparam int PAIRS_PER_WORD = 16;
   localparam int TDO_WORD_W     = 16;

   localparam int CNT_W      = N_MSB - N_LSB + 1;
   localparam int WORD_SHIFT = $clog2(PAIRS_PER_WORD);
   localparam int WCNT_W     = CNT_W - WORD_SHIFT + 1;
   localparam int PAIR_CNT_W = WORD_SHIFT + 1;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DRAIN} state_t;

   // One slot of the TDO capture pipeline.
   typedef struct packed {
      logic vld;
      logic last;
   } cap_ent_t;

   function automatic logic [WCNT_W-1:0] words_for(input logic [CNT_W-1:0] n);
      logic [CNT_W:0] t;
      t = {1'b0, n} + (CNT_W+1)'(PAIRS_PER_WORD - 1);
      return WCNT_W'(t >> WORD_SHIFT);
   endfunction

   // Pairs carried by the word about to be consumed; the final word may be partial.
   function automatic logic [PAIR_CNT_W-1:0] pairs_in_word(input logic [CNT_W-1:0] rem);
      return (rem >= CNT_W'(PAIRS_PER_WORD)) ? PAIR_CNT_W'(PAIRS_PER_WORD)
                                             : rem[PAIR_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/jtag_vector_sequencer_packer.sv
// jtag_tdo_packer: collects captured TDO bits LSB-first into 16-bit words and
// presents them on a valid/ready port; a word completing while the port is stalled is dropped.
module jtag_tdo_packer
   import jtag_seq_pkg::*;
(
   input  logic                  clk_max,
   input  logic                  reset,
   input  logic                  bit_vld,
   input  logic                  bit_in,
   input  logic                  bit_last,
   output logic [TDO_WORD_W-1:0] m_data,
   output logic                  m_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  ovr_evt
);

   localparam int BIT_CNT_W = $clog2(TDO_WORD_W);

   logic [TDO_WORD_W-1:0] acc;
   logic [TDO_WORD_W-1:0] word;
   logic [BIT_CNT_W-1:0]  cnt;
   logic                  done;
   logic                  out_stall;

   // Bits above cnt are always zero in acc, which gives the zero padding for free.
   assign word      = acc | (TDO_WORD_W'(bit_in) << cnt);
   assign done      = bit_vld & (bit_last | (cnt == '1));
   assign out_stall = m_valid & ~m_ready;
   assign ovr_evt   = done & out_stall;

   always_ff @(posedge clk_max) begin
      if (reset) begin
         acc     <= '0;
         cnt     <= '0;
         m_data  <= '0;
         m_last  <= 1'b0;
         m_valid <= 1'b0;
      end else begin
         if (bit_vld) begin
            if (done) begin
               acc <= '0;
               cnt <= '0;
            end else begin
               acc <= word;
               cnt <= cnt + BIT_CNT_W'(1);
            end
         end
         if (done && !out_stall) begin
            m_data  <= word;
            m_last  <= bit_last;
            m_valid <= 1'b1;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/jtag_vector_sequencer.sv
// Sequences (TMS,TDI) pairs from host words to the JTAG pin driver, one per
// driver request, and routes lagged TDO samples into the TDO word packer.
module jtag_vector_sequencer
   import jtag_seq_pkg::*;
#(
   parameter int TDO_LAG = 2
)(
   input  logic                  clk_max,
   input  logic                  reset,
   input  logic [31:0]           s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [TDO_WORD_W-1:0] m_data,
   output logic                  m_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   input  logic                  get_next_data,
   output logic [1:0]            vector_data,
   output logic                  data_ready,
   output logic                  wait_state,
   input  logic                  tdo,
   output logic                  busy,
   output logic                  underrun,
   output logic                  overrun,
   input  logic                  err_clr
);

   localparam int DRAIN_W = $clog2(TDO_LAG + 1);

   state_t                  state, state_nxt;
   logic                    gnd_d, req, rdy_en;
   logic [CNT_W-1:0]        hdr_n, rem_cnt;
   logic [WCNT_W-1:0]       words_owed;
   logic [31:0]             cur_word, next_word, src_word;
   logic [PAIR_CNT_W-1:0]   cur_pairs, src_pairs;
   logic                    next_vld, src_avail;
   logic                    cap_en, idle_tms;
   logic                    s_fire, hdr_fire, word_fire;
   logic                    issue, last_pair, pull;
   logic [DRAIN_W-1:0]      drain_cnt;
   cap_ent_t [TDO_LAG-1:0]  cap_pipe;
   cap_ent_t                cap_in;
   logic                    pk_vld, ovr_evt;

   assign req       = get_next_data & ~gnd_d;
   assign hdr_n     = s_data[N_MSB:N_LSB];
   assign s_ready   = rdy_en & ((state == IDLE) |
                      (((state == LOAD) | (state == SHIFT)) & ~next_vld & (words_owed != '0)));
   assign s_fire    = s_valid & s_ready;
   assign hdr_fire  = s_fire & (state == IDLE);
   assign word_fire = s_fire & (state != IDLE);
   assign busy      = (state != IDLE);

   // A freshly accepted word is usable straight from the next-word register.
   assign src_avail = (cur_pairs != '0) | next_vld;
   assign src_word  = (cur_pairs != '0) ? cur_word : next_word;
   assign src_pairs = (cur_pairs != '0) ? cur_pairs : pairs_in_word(rem_cnt);
   assign issue     = req & (state == SHIFT) & src_avail;
   assign last_pair = issue & (rem_cnt == CNT_W'(1));
   assign pull      = (cur_pairs == '0) & next_vld & ~issue;

   assign cap_in = '{vld: issue & cap_en, last: last_pair};
   assign pk_vld = req & cap_pipe[TDO_LAG-1].vld;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (hdr_fire && hdr_n != '0) state_nxt = LOAD;
         LOAD:    if (word_fire)               state_nxt = SHIFT;
         SHIFT:   if (last_pair)               state_nxt = cap_en ? DRAIN : IDLE;
         DRAIN:   if (req && drain_cnt == DRAIN_W'(TDO_LAG - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_max) begin
      gnd_d <= get_next_data;
      if (reset) begin
         state       <= IDLE;
         rdy_en      <= 1'b0;
         rem_cnt     <= '0;
         words_owed  <= '0;
         cur_word    <= '0;
         cur_pairs   <= '0;
         next_word   <= '0;
         next_vld    <= 1'b0;
         cap_en      <= 1'b0;
         idle_tms    <= 1'b1;
         vector_data <= 2'b10;
         data_ready  <= 1'b0;
         wait_state  <= 1'b1;
         drain_cnt   <= '0;
         cap_pipe    <= '0;
         underrun    <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state  <= state_nxt;
         rdy_en <= 1'b1;

         if (hdr_fire && hdr_n != '0) begin
            rem_cnt    <= hdr_n;
            words_owed <= words_for(hdr_n);
            cap_en     <= s_data[CAP_BIT];
            idle_tms   <= s_data[IDLE_TMS_BIT];
         end else begin
            if (word_fire) words_owed <= words_owed - WCNT_W'(1);
            if (issue)     rem_cnt    <= rem_cnt - CNT_W'(1);
         end

         if (word_fire) begin
            next_word <= s_data;
            next_vld  <= 1'b1;
         end else if (pull || (issue && cur_pairs == '0)) begin
            next_vld  <= 1'b0;
         end

         if (issue) begin
            cur_word  <= src_word >> 2;
            cur_pairs <= src_pairs - PAIR_CNT_W'(1);
         end else if (pull) begin
            cur_word  <= next_word;
            cur_pairs <= pairs_in_word(rem_cnt);
         end

         // Outputs only move on a request so the driver sees a stable pair.
         if (req) begin
            if (issue) {vector_data, data_ready, wait_state} <= {src_word[1:0], 2'b10};
            else       {vector_data, data_ready, wait_state} <= {idle_tms, 3'b001};
            cap_pipe[0] <= cap_in;
            for (int i = 1; i < TDO_LAG; i++) cap_pipe[i] <= cap_pipe[i-1];
         end

         if (state != DRAIN) drain_cnt <= '0;
         else if (req)       drain_cnt <= drain_cnt + DRAIN_W'(1);

         if (req && state == SHIFT && !src_avail) underrun <= 1'b1;
         else if (err_clr)                        underrun <= 1'b0;
         if (ovr_evt)      overrun <= 1'b1;
         else if (err_clr) overrun <= 1'b0;
      end
   end

   jtag_tdo_packer u_packer (
      .clk_max  (clk_max),
      .reset    (reset),
      .bit_vld  (pk_vld),
      .bit_in   (tdo),
      .bit_last (cap_pipe[TDO_LAG-1].last),
      .m_data   (m_data),
      .m_last   (m_last),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .ovr_evt  (ovr_evt)
   );

endmodule

// File: tb/tb_jtag_vector_sequencer.sv
// Scenario bench for jtag_vector_sequencer: expected vectors and TDO words are
// queued as stimulus is driven and popped by negedge monitors.
module tb_jtag_vector_sequencer;

   logic        clk_max = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] m_data;
   logic        m_last, m_valid;
   logic        m_ready = 1'b1;
   logic        get_next_data = 1'b0;
   logic [1:0]  vector_data;
   logic        data_ready, wait_state;
   logic        tdo = 1'b0;
   logic        busy, underrun, overrun;
   logic        err_clr = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   logic [3:0]  exp_vec[$];   // {vector_data, data_ready, wait_state}
   logic [16:0] exp_tdo[$];   // {m_last, m_data}

   always #5 clk_max = ~clk_max;

   jtag_vector_sequencer #(.TDO_LAG(2)) dut (
      .clk_max(clk_max), .reset(reset),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
      .get_next_data(get_next_data), .vector_data(vector_data),
      .data_ready(data_ready), .wait_state(wait_state), .tdo(tdo),
      .busy(busy), .underrun(underrun), .overrun(overrun), .err_clr(err_clr)
   );

   // Vector monitor: one negedge after a request cycle the outputs must hold the next entry.
   initial begin : vec_mon
      logic gnd_prev, pend;
      logic [3:0] obs, exp;
      gnd_prev = 1'b0;
      pend = 1'b0;
      forever begin
         @(negedge clk_max);
         if (pend) begin
            obs = {vector_data, data_ready, wait_state};
            n_chk++;
            if (exp_vec.size() == 0) begin
               n_fail++;
               $display("FAIL vec_unexpected: got %b, required no request", obs);
            end else begin
               exp = exp_vec.pop_front();
               if (obs !== exp) begin
                  n_fail++;
                  $display("FAIL vec: got %b, required %b at %0t", obs, exp, $time);
               end
            end
         end
         pend = get_next_data & ~gnd_prev & ~reset;
         gnd_prev = get_next_data;
      end
   end

   initial begin : tdo_mon
      logic [16:0] obs, exp;
      forever begin
         @(negedge clk_max);
         if (m_valid && m_ready && !reset) begin
            obs = {m_last, m_data};
            n_chk++;
            if (exp_tdo.size() == 0) begin
               n_fail++;
               $display("FAIL tdo_unexpected: got %h, required no word", obs);
            end else begin
               exp = exp_tdo.pop_front();
               if (obs !== exp) begin
                  n_fail++;
                  $display("FAIL tdo_word: got %h, required %h", obs, exp);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic send_word(input logic [31:0] w);
      int t;
      t = 0;
      s_data  = w;
      s_valid = 1'b1;
      @(negedge clk_max);
      while (!s_ready && t < 2000) begin
         @(negedge clk_max);
         t++;
      end
      if (t >= 2000) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: s_ready got 0, required 1 for word %h", w);
      end
      @(posedge clk_max);
      #1 s_valid = 1'b0;
   endtask

   task automatic do_req();
      get_next_data = 1'b1;
      repeat (4) @(posedge clk_max);
      #1 get_next_data = 1'b0;
      repeat (4) @(posedge clk_max);
      #1;
   endtask

   task automatic push_pairs(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) exp_vec.push_back({w[2*i +: 2], 2'b10});
   endtask

   task automatic push_fill(input int n, input logic tms);
      for (int i = 0; i < n; i++) exp_vec.push_back({tms, 3'b001});
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk_max);
      #1;
      n_chk++;
      if ({vector_data, wait_state, data_ready} !== 4'b1010) begin
         n_fail++;
         $display("FAIL reset_vec: got %b, required 1010", {vector_data, wait_state, data_ready});
      end
      n_chk++;
      if ({s_ready, m_valid, m_last, m_data} !== 19'h0) begin
         n_fail++;
         $display("FAIL reset_ports: got %h, required 0", {s_ready, m_valid, m_last, m_data});
      end
      n_chk++;
      if ({busy, underrun, overrun} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b, required 000", {busy, underrun, overrun});
      end
      reset = 1'b0;
      n_chk++;
      if (s_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b, required 0", s_ready);
      end
      @(posedge clk_max);
      #1;
      n_chk++;
      if (s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: got %b, required 1", s_ready);
      end
   endtask

   task automatic test_single_header();
      send_word(32'h0000_0004);
      send_word(32'h0000_00E4);
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_busy: got %b, required 1", busy);
      end
      push_pairs(32'h0000_00E4, 4);
      push_fill(1, 1'b0);
      repeat (5) do_req();
      n_chk++;
      if (busy !== 1'b0 || exp_vec.size() != 0 || exp_tdo.size() != 0) begin
         n_fail++;
         $display("FAIL single_end: busy %b vec_left %0d tdo_left %0d, required 0 0 0",
                  busy, exp_vec.size(), exp_tdo.size());
      end
   endtask

   task automatic test_two_word_capture();
      tdo = 1'b1;
      send_word(32'h0001_0014);
      send_word(32'h1B1B_E4E4);
      send_word(32'h0000_0027);
      push_pairs(32'h1B1B_E4E4, 16);
      push_pairs(32'h0000_0027, 4);
      push_fill(2, 1'b0);
      exp_tdo.push_back({1'b0, 16'hFFFF});
      exp_tdo.push_back({1'b1, 16'h000F});
      repeat (20) do_req();
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL capture_drain_busy: got %b, required 1", busy);
      end
      repeat (2) do_req();
      n_chk++;
      if (busy !== 1'b0 || exp_vec.size() != 0 || exp_tdo.size() != 0) begin
         n_fail++;
         $display("FAIL capture_end: busy %b vec_left %0d tdo_left %0d, required 0 0 0",
                  busy, exp_vec.size(), exp_tdo.size());
      end
      tdo = 1'b0;
   endtask

   task automatic test_starved();
      send_word(32'h0002_0014);
      send_word(32'h6C93_A5F0);
      push_pairs(32'h6C93_A5F0, 16);
      repeat (16) do_req();
      n_chk++;
      if (underrun !== 1'b0) begin
         n_fail++;
         $display("FAIL starve_pre: underrun got %b, required 0", underrun);
      end
      push_fill(3, 1'b1);
      repeat (3) do_req();
      n_chk++;
      if ({underrun, busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL starve_flag: {underrun,busy} got %b, required 11", {underrun, busy});
      end
      send_word(32'h0000_00B4);
      push_pairs(32'h0000_00B4, 4);
      repeat (4) do_req();
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL starve_done: busy got %b, required 0", busy);
      end
      push_fill(1, 1'b1);
      do_req();
      err_clr = 1'b1;
      @(posedge clk_max);
      #1 err_clr = 1'b0;
      n_chk++;
      if (underrun !== 1'b0 || exp_vec.size() != 0) begin
         n_fail++;
         $display("FAIL starve_clear: underrun %b vec_left %0d, required 0 0",
                  underrun, exp_vec.size());
      end
   endtask

   task automatic test_backpressure();
      tdo = 1'b1;
      m_ready = 1'b0;
      send_word(32'h0001_0020);
      send_word(32'hFFFF_0000);
      send_word(32'h5555_AAAA);
      push_pairs(32'hFFFF_0000, 16);
      push_pairs(32'h5555_AAAA, 16);
      push_fill(2, 1'b0);
      repeat (34) do_req();
      n_chk++;
      if ({m_valid, m_last, m_data} !== {2'b10, 16'hFFFF}) begin
         n_fail++;
         $display("FAIL bp_held: {valid,last,data} got %h, required %h",
                  {m_valid, m_last, m_data}, {2'b10, 16'hFFFF});
      end
      n_chk++;
      if (overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_overrun: got %b, required 1", overrun);
      end
      exp_tdo.push_back({1'b0, 16'hFFFF});
      m_ready = 1'b1;
      @(posedge clk_max);
      #1;
      n_chk++;
      if (m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: m_valid got %b, required 0", m_valid);
      end
      err_clr = 1'b1;
      @(posedge clk_max);
      #1 err_clr = 1'b0;
      n_chk++;
      if (overrun !== 1'b0 || exp_tdo.size() != 0) begin
         n_fail++;
         $display("FAIL bp_clear: overrun %b tdo_left %0d, required 0 0", overrun, exp_tdo.size());
      end
      tdo = 1'b0;
   endtask

   task automatic test_reset_zero_count();
      tdo = 1'b1;
      send_word(32'h0001_0010);
      send_word(32'h1234_5678);
      push_pairs(32'h1234_5678, 5);
      repeat (5) do_req();
      reset = 1'b1;
      @(posedge clk_max);
      #1 reset = 1'b0;
      n_chk++;
      if ({vector_data, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL midreset: {vector_data,busy} got %b, required 100", {vector_data, busy});
      end
      @(posedge clk_max);
      #1;
      send_word(32'h0003_0000);
      @(posedge clk_max);
      #1;
      n_chk++;
      if ({busy, s_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL zero_count: {busy,s_ready} got %b, required 01", {busy, s_ready});
      end
      push_fill(2, 1'b1);
      repeat (2) do_req();
      n_chk++;
      if (exp_vec.size() != 0 || m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_end: vec_left %0d m_valid %b, required 0 0", exp_vec.size(), m_valid);
      end
      tdo = 1'b0;
   endtask

   task automatic test_back_to_back();
      push_pairs(32'h1E1E_C3C3, 16);
      push_pairs(32'h9A9A_6565, 16);
      push_fill(2, 1'b0);
      exp_tdo.push_back({1'b1, 16'h0000});
      fork
         begin
            send_word(32'h0000_0010);
            send_word(32'h1E1E_C3C3);
            send_word(32'h0001_0010);
            send_word(32'h9A9A_6565);
         end
         begin
            repeat (6) @(posedge clk_max);
            #1;
            repeat (34) do_req();
         end
      join
      n_chk++;
      if (busy !== 1'b0 || exp_vec.size() != 0 || exp_tdo.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_end: busy %b vec_left %0d tdo_left %0d, required 0 0 0",
                  busy, exp_vec.size(), exp_tdo.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_header();
      test_two_word_capture();
      test_starved();
      test_backpressure();
      test_reset_zero_count();
      test_back_to_back();
      repeat (4) @(posedge clk_max);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
